block_stream_gen: RTL and testbench

Parametrised falling-block row generator for the block game. A configurable-period step counter scrolls a ROWS-deep stack of LANES-wide rows toward the bottom. On every step a pseudo-random one-hot row enters at the top and the bottom row leaves the stack. Player hits clear bits in the bottom row, and bits still set when their row leaves the stack count as misses. The block sits between the game controller (period, run, seed, hit inputs) and the display driver (Disp_num).

---
 rtl/block_pkg.sv | 24 ++
 rtl/block_lfsr.sv | 27 ++
 rtl/block_stream_gen.sv | 76 +++++++
 tb/tb_block_stream_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// Shared constants and helpers for the falling-block row generator.
// LFSR reset/taps plus elaboration-time clog2 and a row popcount.
package block_pkg;

  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++)
      c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/block_lfsr.sv
// 16-bit right-shifting Galois LFSR that picks the lane of each new row.
// A seed load wins over an advance in the same cycle.
module block_lfsr
  import block_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] nxt;

  assign nxt = (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= LFSR_RESET;
    else if (load)
      q <= (seed == 16'h0000) ? LFSR_RESET : seed;
    else if (adv)
      q <= nxt;
  end

endmodule

// File: rtl/block_stream_gen.sv
// Scrolling row stack for the block game: a periodic step shifts rows
// down, injects a one-hot row on top and scores unhit bits as misses.
module block_stream_gen
  import block_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ROWS   = 8,
  parameter int MISS_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [31:0]           gene_time,
  input  logic                  seed_load,
  input  logic [15:0]           seed,
  input  logic [LANES-1:0]      hit,
  output logic [ROWS*LANES-1:0] Disp_num,
  output logic                  EN,
  output logic                  miss,
  output logic                  hit_ok,
  output logic [MISS_W-1:0]     miss_cnt
);

  localparam int LW = clog2(LANES);
  localparam int PW = LW + 1;

  logic [ROWS-1:0][LANES-1:0] rows;
  logic [31:0]                counter;
  logic [15:0]                lfsr;
  logic                       step;
  logic [LANES-1:0]           eff0;
  logic [LANES-1:0]           new_row;
  logic [PW-1:0]              pc;
  logic [MISS_W:0]            sum;

  block_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (step),
    .load (seed_load),
    .seed (seed),
    .q    (lfsr)
  );

  assign step     = run && (counter == gene_time);
  // Hits land before the bottom row departs, so a same-cycle hit is no miss.
  assign eff0     = rows[0] & ~hit;
  assign new_row  = LANES'(1) << lfsr[LW-1:0];
  assign pc       = PW'(popcount(32'(eff0)));
  assign sum      = {1'b0, miss_cnt} + (MISS_W+1)'(pc);
  assign Disp_num = rows;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows     <= '0;
      counter  <= '0;
      EN       <= 1'b0;
      miss     <= 1'b0;
      hit_ok   <= 1'b0;
      miss_cnt <= '0;
    end else begin
      hit_ok <= |(rows[0] & hit);
      EN     <= step;
      miss   <= step && |eff0;
      if (run)
        counter <= step ? 32'd0 : counter + 32'd1;
      if (step) begin
        rows     <= {new_row, rows[ROWS-1:1]};
        miss_cnt <= sum[MISS_W] ? '1 : sum[MISS_W-1:0];
      end else begin
        rows[0] <= eff0;
      end
    end
  end

endmodule

// File: tb/tb_block_stream_gen.sv
// Directed bench for block_stream_gen: a reference model pushes expected
// step results to a queue that is drained whenever the DUT pulses EN.
module tb_block_stream_gen;

  localparam int LANES  = 4;
  localparam int ROWS   = 8;
  localparam int MISS_W = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  run = 1'b0;
  logic [31:0]           gene_time = 32'd3;
  logic                  seed_load = 1'b0;
  logic [15:0]           seed = 16'h0;
  logic [LANES-1:0]      hit = '0;
  logic [ROWS*LANES-1:0] disp;
  logic                  en;
  logic                  miss;
  logic                  hit_ok;
  logic [MISS_W-1:0]     miss_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [ROWS*LANES-1:0] disp;
    logic                  miss;
    logic [MISS_W-1:0]     cnt;
  } exp_t;

  exp_t sb[$];

  logic [LANES-1:0]  m_rows [ROWS];
  logic [15:0]       m_lfsr;
  logic [31:0]       m_cnt;
  logic [MISS_W-1:0] m_miss;
  logic              m_hitok;

  block_stream_gen #(
    .LANES  (LANES),
    .ROWS   (ROWS),
    .MISS_W (MISS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .gene_time (gene_time),
    .seed_load (seed_load),
    .seed      (seed),
    .hit       (hit),
    .Disp_num  (disp),
    .EN        (en),
    .miss      (miss),
    .hit_ok    (hit_ok),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROWS*LANES-1:0] m_pack();
    logic [ROWS*LANES-1:0] v;
    v = '0;
    for (int k = 0; k < ROWS; k++)
      v[k*LANES +: LANES] = m_rows[k];
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < ROWS; k++)
      m_rows[k] = '0;
    m_lfsr  = 16'hACE1;
    m_cnt   = 0;
    m_miss  = '0;
    m_hitok = 1'b0;
  endtask

  task automatic tick(input logic [LANES-1:0] h);
    logic [LANES-1:0] eff;
    logic             stp;
    int               s;
    exp_t             e;
    exp_t             got;
    hit     = h;
    stp     = run && (m_cnt == gene_time);
    eff     = m_rows[0] & ~h;
    m_hitok = |(m_rows[0] & h);
    if (stp) begin
      for (int k = 0; k < ROWS - 1; k++)
        m_rows[k] = m_rows[k+1];
      m_rows[ROWS-1] = LANES'(1) << m_lfsr[1:0];
      s = int'(m_miss) + $countones(eff);
      m_miss = (s > 65535) ? '1 : MISS_W'(s);
      e.disp = m_pack();
      e.miss = |eff;
      e.cnt  = m_miss;
      sb.push_back(e);
    end else begin
      m_rows[0] = eff;
    end
    if (run)
      m_cnt = stp ? 0 : m_cnt + 1;
    if (seed_load)
      m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    else if (stp)
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
    @(posedge clk);
    #1;
    hit = '0;
    chk("en", 64'(en), 64'(stp));
    chk("hit_ok", 64'(hit_ok), 64'(m_hitok));
    chk("disp", 64'(disp), 64'(m_pack()));
    if (!en)
      chk("miss_idle", 64'(miss), 64'd0);
    if (en && sb.size() > 0) begin
      got = sb.pop_front();
      chk("sb_disp", 64'(disp), 64'(got.disp));
      chk("sb_miss", 64'(miss), 64'(got.miss));
      chk("sb_cnt", 64'(miss_cnt), 64'(got.cnt));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_disp"}, 64'(disp), 64'd0);
    chk({tag, "_en"}, 64'(en), 64'd0);
    chk({tag, "_miss"}, 64'(miss), 64'd0);
    chk({tag, "_hitok"}, 64'(hit_ok), 64'd0);
    chk({tag, "_cnt"}, 64'(miss_cnt), 64'd0);
  endtask

  initial begin
    logic [MISS_W-1:0]     c0;
    logic [ROWS*LANES-1:0] d0;
    int                    n;

    m_reset();
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;

    repeat (4) tick('0);
    chk("top1", 64'(disp[31:28]), 64'h2);
    repeat (4) tick('0);
    chk("top2", 64'(disp[31:28]), 64'h1);
    chk("shift", 64'(disp[27:24]), 64'h2);

    repeat (20) tick('0);
    chk("row0_s7", 64'(disp[3:0]), 64'h0);
    repeat (4) tick('0);
    chk("row0_s8", 64'(disp[3:0]), 64'h2);
    repeat (4) tick('0);
    chk("miss_s9", 64'(miss), 64'd1);
    chk("cnt_s9", 64'(miss_cnt), 64'd1);

    tick('0);
    tick(m_rows[0]);
    chk("hit_clr", 64'(disp[3:0]), 64'h0);
    chk("hit_ok1", 64'(hit_ok), 64'd1);
    c0 = m_miss;
    repeat (2) tick('0);
    chk("hit_nomiss", 64'(miss), 64'd0);
    chk("hit_cnt", 64'(miss_cnt), 64'(c0));

    repeat (3) tick('0);
    c0 = m_miss;
    tick(m_rows[0]);
    chk("stephit_en", 64'(en), 64'd1);
    chk("stephit_miss", 64'(miss), 64'd0);
    chk("stephit_cnt", 64'(miss_cnt), 64'(c0));

    repeat (2) tick('0);
    d0 = disp;
    run = 1'b0;
    repeat (10) tick('0);
    chk("frozen", 64'(disp), 64'(d0));
    run = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick('0);
      n++;
      if (en) break;
    end
    chk("resume_gap", 64'(n), 64'd2);

    tick('0);
    seed_load = 1'b1;
    seed = 16'h0000;
    tick('0);
    seed_load = 1'b0;
    repeat (2) tick('0);
    chk("seed0_top", 64'(disp[31:28]), 64'h2);

    tick('0);
    seed_load = 1'b1;
    seed = 16'h0003;
    tick('0);
    seed_load = 1'b0;
    repeat (2) tick('0);
    chk("seed3_top", 64'(disp[31:28]), 64'h8);

    gene_time = 32'd0;
    repeat (6) tick('0);
    chk("gt0_en", 64'(en), 64'd1);
    gene_time = 32'd3;

    repeat (2) tick('0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    m_reset();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick('0);
    chk("post_rst_top", 64'(disp[31:28]), 64'h2);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
